// File: rtl/reg_file.sv
// 32x32 CPU register file: two combinational read ports, one clocked write port, r0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en;

    assign wr_en = we && !rst && (waddr != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: this memory is reset on purpose: the CPU relies on every register reading 0 after reset.
    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (waddr == raddr1)) begin
                rdata1 = wdata;
            end
`endif
        end
        if (raddr2 != '0) begin
            rdata2 = mem_q[raddr2];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (waddr == raddr2)) begin
                rdata2 = wdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] model [32];

    reg_file #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value from the register-file rules, applied to the array model.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return model[a];
    endfunction

    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end
        #1;
    endtask

    // Advance one rising edge, updating the model from the inputs present before it.
    task automatic tick();
        logic        commit;
        logic [4:0]  wa;
        logic [31:0] wd;
        commit = we && !rst && (waddr != 5'd0);
        wa = waddr;
        wd = wdata;
        @(posedge clk);
        if (commit) model[wa] = wd;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we = 1'b0;
        #1;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_rd1"}, rdata1, exp_read(raddr1));
        check({tag, "_rd2"}, rdata2, exp_read(raddr2));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Power-on reset
        #1;
        set_rst(1'b1);
        tick();
        set_rst(1'b0);
        check_reads("por");

        // Reset sweep with random prior contents
        for (int i = 1; i < 32; i++) wr(5'(i), $urandom);
        raddr1 = 5'd3;
        check_reads("prefill");
        #1;
        set_rst(1'b1);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check("rst_sweep_rd1", rdata1, 32'h0);
            check("rst_sweep_rd2", rdata2, 32'h0);
        end
        tick();
        set_rst(1'b0);

        // Reset pulse between edges clears without a clock edge
        wr(5'd12, 32'hCAFE_F00D);
        raddr1 = 5'd12;
        #1;
        check("pulse_pre", rdata1, 32'hCAFE_F00D);
        set_rst(1'b1);
        set_rst(1'b0);
        check("pulse_post", rdata1, 32'h0);

        // Write then read
        wr(5'd5, 32'hDEAD_BEEF);
        wr(5'd6, 32'h0000_0033);
        raddr1 = 5'd5;
        raddr2 = 5'd6;
        #1;
        check("wr_r5", rdata1, 32'hDEAD_BEEF);
        check("wr_r6", rdata2, 32'h0000_0033);
        we = 1'b0;
        waddr = 5'd5;
        wdata = 32'hFFFF_FFFF;
        tick();
        check("we0_r5", rdata1, 32'hDEAD_BEEF);

        // Register 0 is never written
        wr(5'd0, 32'h1234_5678);
        raddr1 = 5'd0;
        #1;
        check("r0_read", rdata1, 32'h0);
        for (int i = 1; i < 32; i++) begin
            raddr2 = 5'(i);
            #1;
            check("r0_others", rdata2, model[i]);
        end

        // Same-address read/write in one cycle
        wr(5'd7, 32'h0000_0011);
        we = 1'b1;
        waddr = 5'd7;
        wdata = 32'h0000_00FF;
        raddr2 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_pre", rdata2, 32'h0000_00FF);
`else
        check("same_pre", rdata2, 32'h0000_0011);
`endif
        tick();
        we = 1'b0;
        #1;
        check("same_post", rdata2, 32'h0000_00FF);

        // Reset during write
        we = 1'b1;
        waddr = 5'd9;
        wdata = 32'h0000_00AA;
        raddr1 = 5'd9;
        set_rst(1'b1);
        tick();
        we = 1'b0;
        #1;
        check("rst_wr_lost_in", rdata1, 32'h0);
        set_rst(1'b0);
        check("rst_wr_lost", rdata1, 32'h0);
        wr(5'd9, 32'h0000_00AA);
        check("rst_wr_again", rdata1, 32'h0000_00AA);

        // Dual read of the same and different registers
        wr(5'd31, 32'hAAAA_AAAA);
        wr(5'd1, 32'h5555_5555);
        raddr1 = 5'd31;
        raddr2 = 5'd31;
        #1;
        check("dual_rd1", rdata1, 32'hAAAA_AAAA);
        check("dual_rd2", rdata2, 32'hAAAA_AAAA);
        raddr2 = 5'd1;
        #1;
        check("dual_rd2_r1", rdata2, 32'h5555_5555);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom);
            waddr = 5'($urandom);
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            check_reads("rnd_pre");
            if ($urandom_range(0, 39) == 0) begin
                set_rst(1'b1);
                check_reads("rnd_rst");
                tick();
                set_rst(1'b0);
            end else begin
                tick();
            end
            check_reads("rnd_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
